// File: rtl/cubehash_sched_if.sv
// Block-input and round-engine command bundle for cubehash_sched.
// master = scheduler side, slave = assembler / round-engine side.
interface cubehash_sched_if #(
    parameter int RW = 8
);
    logic           blk_valid;
    logic [255:0]   blk_data;
    logic           blk_last;
    logic           blk_ready;
    logic           eng_start;
    logic [1:0]     eng_cmd;
    logic [RW-1:0]  eng_rounds;
    logic [255:0]   eng_blk;
    logic           eng_done;

    modport master (
        input  blk_valid,
        input  blk_data,
        input  blk_last,
        input  eng_done,
        output blk_ready,
        output eng_start,
        output eng_cmd,
        output eng_rounds,
        output eng_blk
    );

    modport slave (
        output blk_valid,
        output blk_data,
        output blk_last,
        output eng_done,
        input  blk_ready,
        input  eng_start,
        input  eng_cmd,
        input  eng_rounds,
        input  eng_blk
    );
endinterface

// File: rtl/cubehash_sched.sv
// CubeHash command sequencer: 2-entry block buffer, INIT/ABSORB/FINAL issue.
// Optional BLK_CNT_EN adds o_blk_count (ABSORB commands since last start).
module cubehash_sched #(
    parameter int R           = 16,
    parameter int INIT_ROUNDS = 160,
    parameter int FIN_ROUNDS  = 160,
    parameter int RW          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    cubehash_sched_if.master   bus,
    output logic               o_busy,
    output logic               o_hash_valid,
    output logic               o_overflow
`ifdef BLK_CNT_EN
    ,
    output logic [31:0]        o_blk_count
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE_INIT,
        S_WAIT_INIT,
        S_GET_BLK,
        S_ISSUE_ABS,
        S_WAIT_ABS,
        S_ISSUE_FIN,
        S_WAIT_FIN,
        S_DONE
    } state_t;

    localparam logic [1:0]    CMD_INIT = 2'b00;
    localparam logic [1:0]    CMD_ABS  = 2'b01;
    localparam logic [1:0]    CMD_FIN  = 2'b10;
    localparam logic [RW-1:0] RND_INIT = RW'(INIT_ROUNDS);
    localparam logic [RW-1:0] RND_ABS  = RW'(R);
    localparam logic [RW-1:0] RND_FIN  = RW'(FIN_ROUNDS);

    state_t          r_state;
    logic            r_eng_start;
    logic [1:0]      r_eng_cmd;
    logic [RW-1:0]   r_eng_rounds;
    logic [255:0]    r_eng_blk;
    logic            r_last;
    logic            r_busy;
    logic            r_hash_valid;
    logic            r_overflow;

    // Buffer entry layout: {data[255:0], last}
    logic [256:0]    r_mem [2];
    logic            r_wr_ptr;
    logic            r_rd_ptr;
    logic [1:0]      r_count;

    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [256:0]    w_head;

    assign w_pop  = (r_state == S_GET_BLK) && (r_count != 2'd0);
    assign w_push = bus.blk_valid && ((r_count != 2'd2) || w_pop);
    assign w_drop = bus.blk_valid && !w_push;
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.blk_data, bus.blk_last};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Command fields change only when entering an ISSUE_* state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_eng_start  <= 1'b0;
            r_eng_cmd    <= CMD_INIT;
            r_eng_rounds <= '0;
            r_eng_blk    <= '0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_hash_valid <= 1'b0;
        end else begin
            r_eng_start  <= 1'b0;
            r_hash_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_ISSUE_INIT;
                        r_eng_start  <= 1'b1;
                        r_eng_cmd    <= CMD_INIT;
                        r_eng_rounds <= RND_INIT;
                        r_busy       <= 1'b1;
                    end
                end
                S_ISSUE_INIT: begin
                    r_state <= S_WAIT_INIT;
                end
                S_WAIT_INIT: begin
                    if (bus.eng_done) begin
                        r_state <= S_GET_BLK;
                    end
                end
                S_GET_BLK: begin
                    if (w_pop) begin
                        r_state      <= S_ISSUE_ABS;
                        r_eng_start  <= 1'b1;
                        r_eng_cmd    <= CMD_ABS;
                        r_eng_rounds <= RND_ABS;
                        r_eng_blk    <= w_head[256:1];
                        r_last       <= w_head[0];
                    end
                end
                S_ISSUE_ABS: begin
                    r_state <= S_WAIT_ABS;
                end
                S_WAIT_ABS: begin
                    if (bus.eng_done) begin
                        if (r_last) begin
                            r_state      <= S_ISSUE_FIN;
                            r_eng_start  <= 1'b1;
                            r_eng_cmd    <= CMD_FIN;
                            r_eng_rounds <= RND_FIN;
                        end else begin
                            r_state <= S_GET_BLK;
                        end
                    end
                end
                S_ISSUE_FIN: begin
                    r_state <= S_WAIT_FIN;
                end
                S_WAIT_FIN: begin
                    if (bus.eng_done) begin
                        r_state      <= S_DONE;
                        r_hash_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef BLK_CNT_EN
    logic [31:0] r_blk_count;

    // Every pop starts exactly one ABSORB, so pops are the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blk_count <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_blk_count <= '0;
        end else if (w_pop) begin
            r_blk_count <= r_blk_count + 32'd1;
        end
    end

    assign o_blk_count = r_blk_count;
`endif

    assign bus.blk_ready  = (r_count != 2'd2);
    assign bus.eng_start  = r_eng_start;
    assign bus.eng_cmd    = r_eng_cmd;
    assign bus.eng_rounds = r_eng_rounds;
    assign bus.eng_blk    = r_eng_blk;
    assign o_busy         = r_busy;
    assign o_hash_valid   = r_hash_valid;
    assign o_overflow     = r_overflow;

endmodule

// File: doc/cubehash_sched.md
Name: cubehash_sched

Overview:
- Controller that sequences the CubeHash round engine over a stream of 256-bit message blocks.
- Accepts each assembled block (256-bit word plus one-cycle done pulse) from the byte-to-block assembler and holds it in a 2-entry block buffer.
- Issues INIT, ABSORB and FINAL commands to the round engine with a start/done handshake, then pulses hash_valid when finalization completes.
- Sits between the input assembler and the round engine; contains no round arithmetic.

Parameters:
- R, 16: rounds per absorbed block.
- INIT_ROUNDS, 160: rounds for the initialization command (10*R).
- FIN_ROUNDS, 160: rounds for the finalization command (10*R).
- RW, 8: width of eng_rounds; every round parameter must be below 2^RW.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous reset, active-low; sampled on rising clk.
- start  in  1  one-cycle pulse that begins a new hash; honoured only in IDLE.
- blk_valid  in  1  one-cycle pulse: blk_data/blk_last valid (assembler done).
- blk_data  in  256  message block, byte 0 in bits [255:248].
- blk_last  in  1  qualifies blk_valid: this is the final block of the message.
- blk_ready  out  1  high while the buffer can accept a block (count<2).
- eng_start  out  1  one-cycle command strobe to the round engine.
- eng_cmd  out  2  00=INIT, 01=ABSORB (XOR eng_blk into state, then rounds), 10=FINAL (XOR 1 into state word 31, then rounds).
- eng_rounds  out  RW  round count for the current command.
- eng_blk  out  256  block for ABSORB; held stable from eng_start until eng_done.
- eng_done  in  1  one-cycle pulse from the engine: command complete.
- busy  out  1  high in every state except IDLE.
- hash_valid  out  1  one-cycle pulse: engine state holds the final digest.
- overflow  out  1  sticky flag: a block was dropped because the buffer was full.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, buffer count 0.
  - eng_start, eng_cmd, eng_rounds, eng_blk, hash_valid, overflow and busy all 0.
  - blk_ready=1 (buffer empty).
  - Reset mid-command abandons the command. Any later eng_done is ignored until a new command is issued.
- Buffer: 2-entry FIFO, 257 bits per entry (data + last).
  - Push when blk_valid=1 and (count<2 or a pop occurs the same cycle).
  - blk_valid with count==2 and no pop: block dropped, overflow set to 1 until reset.
  - Pushes are accepted in every state, including IDLE and INIT.
  - Push and pop in the same cycle keep count unchanged and preserve order.
- States:
  - IDLE: start=1 -> ISSUE_INIT.
  - ISSUE_INIT: eng_start=1, eng_cmd=00, eng_rounds=INIT_ROUNDS for one cycle -> WAIT_INIT.
  - WAIT_INIT: eng_done=1 -> GET_BLK.
  - GET_BLK: count>0 -> pop the head into eng_blk and the internal last flag -> ISSUE_ABS. Otherwise wait.
  - ISSUE_ABS: eng_start=1, eng_cmd=01, eng_rounds=R -> WAIT_ABS.
  - WAIT_ABS: eng_done=1 -> ISSUE_FIN if last=1, else GET_BLK.
  - ISSUE_FIN: eng_start=1, eng_cmd=10, eng_rounds=FIN_ROUNDS -> WAIT_FIN.
  - WAIT_FIN: eng_done=1 -> DONE.
  - DONE: hash_valid=1 for one cycle -> IDLE.
- Latency:
  - start -> eng_start: 1 cycle.
  - eng_done in WAIT_ABS with buffer non-empty -> next ABSORB eng_start: 2 cycles.
  - eng_done in WAIT_FIN -> hash_valid: 1 cycle.
  - hash_valid -> IDLE: 1 cycle; the next start is accepted the cycle after hash_valid.
- eng_done is ignored outside the WAIT_* states and on the same cycle as eng_start.
- start outside IDLE is ignored.
- Blocks left in the buffer after a hash completes stay queued and feed the next hash after its INIT.
- eng_cmd, eng_rounds and eng_blk are registered and hold their value until the next ISSUE_* state.
- Message length is a multiple of 32 bytes; padding is applied upstream.

Optional Feature:
- BLK_CNT_EN defined: adds output blk_count [31:0].
  - Counts ABSORB commands issued since the last start; wraps at 2^32.
  - Cleared to 0 on reset and on an accepted start.
  - Stable from hash_valid until the next accepted start.
- BLK_CNT_EN undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then single block: start; engine model answers eng_done 5 cycles after each eng_start; one blk_valid with blk_last=1 and blk_data=256'hA5..A5.
  - Expect the command sequence INIT(160), ABSORB(16, eng_blk=A5..A5), FINAL(160).
  - Expect exactly one hash_valid pulse, then busy=0.
- Three blocks (D0, D1, D2, last on D2) pushed back-to-back during INIT: D0 and D1 are buffered and blk_ready=0 after the second push.
  - D2 sent after the first pop.
  - Expect ABSORB order D0, D1, D2, then FINAL; overflow=0.
- Overflow: push 3 blocks while in WAIT_INIT with no pop.
  - Expect overflow=1 sticky and the third block absent from the ABSORB sequence.
- Simultaneous push and pop: blk_valid arrives in the GET_BLK cycle with count==2.
  - Expect the block accepted, count stays 2, FIFO order kept.
- Spurious inputs: eng_done pulsed in IDLE and GET_BLK, start pulsed in WAIT_ABS.
  - Expect no state change and no extra eng_start.
- Reset mid-operation: assert rst_n=0 for 1 cycle in WAIT_ABS.
  - Expect all outputs at their reset values and blk_ready=1.
  - A later eng_done is ignored; a fresh start restarts with INIT.
  - With BLK_CNT_EN defined, blk_count=0 after the reset and equals 3 at hash_valid in the three-block scenario.
